// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore FSM sequencing a shared-ALU, shared-memory multi-cycle core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_count;
  logic             w_retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op_q  <= 6'd0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  // Only terminal states of a completed instruction ever return to FETCH.
  assign w_retire    = (w_next == S_FETCH) && (r_state != S_FETCH);
  assign instr_count = r_count;
  assign state       = r_state;

  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == c_OP_RTYPE)                         w_next = S_EXEC;
        else if (opcode == c_OP_LW || opcode == c_OP_SW)  w_next = S_MEM_ADDR;
        else if (opcode == c_OP_BEQ)                      w_next = S_BRANCH;
        else if (ENABLE_JUMP && opcode == c_OP_J)         w_next = S_JUMP;
        else if (ENABLE_ADDI && opcode == c_OP_ADDI)      w_next = S_ADDI_EX;
        else                                              w_next = S_TRAP;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (r_op_q == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        w_next    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed bench for the default controller and a no-jump, 4-bit counter variant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rwr, a_srca, a_ill;
  logic [1:0] a_srcb, a_aluop, a_pcsrc;
  logic [31:0] a_cnt;
  logic [3:0] a_st;

  logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rwr, b_srca, b_ill;
  logic [1:0] b_srcb, b_aluop, b_pcsrc;
  logic [3:0] b_cnt;
  logic [3:0] b_st;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(a_pcw), .pc_write_cond(a_pcwc), .i_or_d(a_iord), .mem_read(a_mrd),
    .mem_write(a_mwr), .ir_write(a_irw), .mem_to_reg(a_m2r), .reg_dst(a_rdst),
    .reg_write(a_rwr), .alu_src_a(a_srca), .alu_src_b(a_srcb), .alu_op(a_aluop),
    .pc_source(a_pcsrc), .illegal_op(a_ill), .instr_count(a_cnt), .state(a_st)
  );

  multicycle_control #(.ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(b_pcw), .pc_write_cond(b_pcwc), .i_or_d(b_iord), .mem_read(b_mrd),
    .mem_write(b_mwr), .ir_write(b_irw), .mem_to_reg(b_m2r), .reg_dst(b_rdst),
    .reg_write(b_rwr), .alu_src_a(b_srca), .alu_src_b(b_srcb), .alu_op(b_aluop),
    .pc_source(b_pcsrc), .illegal_op(b_ill), .instr_count(b_cnt), .state(b_st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(a_st), 32'd0);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_ill", 32'(a_ill), 32'd0);
    chk("fetch_ctl", {a_mrd, a_irw, a_pcw, a_iord, a_srca, a_srcb, a_aluop, a_pcsrc}, 32'b111_0_0_01_00_00);

    // R-type
    tick(); chk("r_dec", {a_st, a_srcb, a_irw}, {4'd1, 2'b11, 1'b0});
    tick(); chk("r_exec", {a_st, a_aluop, a_srca, a_srcb}, {4'd6, 2'b10, 1'b1, 2'b00});
    tick(); chk("r_wb", {a_st, a_rwr, a_rdst, a_m2r}, {4'd7, 3'b110});
    chk("r_cnt_pre", a_cnt, 32'd0);
    tick(); chk("r_done", {a_st, a_cnt[3:0], b_cnt}, {4'd0, 4'd1, 4'd1});

    // lw with two wait cycles in MEM_RD; opcode changes after DECODE are ignored
    opcode = 6'b100011;
    tick(); chk("lw_dec", 32'(a_st), 32'd1);
    tick(); chk("lw_addr", {a_st, a_srca, a_srcb}, {4'd2, 1'b1, 2'b10});
    opcode = 6'b101011;
    tick(); mem_ready = 1'b0; #1;
    chk("lw_rd0", {a_st, a_mrd, a_iord, a_mwr}, {4'd3, 3'b110});
    tick(); chk("lw_rd1", {a_st, a_mrd, a_iord}, {4'd3, 2'b11});
    tick(); mem_ready = 1'b1; #1;
    chk("lw_rd2", {a_st, a_mrd, a_iord}, {4'd3, 2'b11});
    tick(); chk("lw_wb", {a_st, a_rwr, a_m2r, a_rdst}, {4'd4, 3'b110});
    tick(); chk("lw_done", {a_st, a_cnt[3:0]}, {4'd0, 4'd2});

    // FETCH stalled three cycles, then beq
    opcode = 6'b000100; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("fetch_wait", {a_st, a_irw, a_pcw, a_mrd}, {4'd0, 3'b001});
      tick();
    end
    chk("fetch_hold", 32'(a_st), 32'd0);
    mem_ready = 1'b1; #1;
    chk("fetch_go", {a_irw, a_pcw}, 32'b11);
    tick(); chk("beq_dec", 32'(a_st), 32'd1);
    tick(); chk("beq_br", {a_st, a_pcwc, a_pcsrc, a_aluop, a_srca, a_srcb}, {4'd8, 1'b1, 2'b01, 2'b01, 1'b1, 2'b00});
    tick(); chk("beq_cnt", a_cnt, 32'd3);

    // j: legal on dut_a, trap on dut_b
    opcode = 6'b000010;
    tick();
    tick(); chk("j_jump", {a_st, a_pcw, a_pcsrc}, {4'd9, 1'b1, 2'b10});
    chk("j_trap", {b_st, b_ill, b_pcw, b_mrd, b_irw, b_rwr, b_mwr}, {4'd12, 1'b1, 5'b0});
    tick(); chk("j_cnt", {a_st, a_cnt[3:0], b_cnt}, {4'd0, 4'd4, 4'd3});

    // addi; dut_b must stay trapped regardless of opcode
    opcode = 6'b001000;
    tick(); chk("addi_dec", 32'(a_st), 32'd1);
    tick(); chk("addi_ex", {a_st, a_srca, a_srcb, a_aluop}, {4'd10, 1'b1, 2'b10, 2'b00});
    tick(); chk("addi_wb", {a_st, a_rwr, a_rdst, a_m2r}, {4'd11, 3'b100});
    chk("trap_hold", {b_st, b_ill, b_cnt}, {4'd12, 1'b1, 4'd3});
    tick(); chk("addi_cnt", a_cnt, 32'd5);

    // sw completing with no wait
    opcode = 6'b101011;
    tick(); tick(); tick();
    chk("sw_wr", {a_st, a_mwr, a_iord, a_mrd}, {4'd5, 3'b110});
    tick(); chk("sw_cnt", {a_st, a_cnt[3:0]}, {4'd0, 4'd6});

    // sw with a wait cycle, then reset in MEM_WR while mem_ready is high
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk("sw_wait", {a_st, a_mwr}, {4'd5, 1'b1});
    tick(); chk("sw_wait2", {a_st, a_mwr}, {4'd5, 1'b1});
    mem_ready = 1'b1; reset = 1'b1;
    tick(); reset = 1'b0; #1;
    chk("rst_mwr", {a_st, a_cnt[3:0]}, {4'd0, 4'd0});
    chk("rst_cnt_hi", a_cnt, 32'd0);
    chk("rst_trap", {b_st, b_ill, b_cnt}, {4'd0, 1'b0, 4'd0});

    // 16 R-types: 4-bit counter wraps
    opcode = 6'b000000;
    for (int i = 0; i < 15; i++) begin
      tick(); tick(); tick(); tick();
    end
    chk("wrap_15", {b_cnt, a_cnt[7:0]}, {4'd15, 8'd15});
    tick(); tick(); tick(); tick();
    chk("wrap_16", {b_st, b_cnt}, {4'd0, 4'd0});
    chk("nowrap_32", a_cnt, 32'd16);

    // unknown opcode traps the default build too
    opcode = 6'b111111;
    tick(); tick();
    chk("bad_op", {a_st, a_ill, a_mrd, a_pcw}, {4'd12, 1'b1, 2'b00});
    tick(); chk("bad_hold", {a_st, a_cnt[7:0]}, {4'd12, 8'd16});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder. A Moore FSM sequences fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one memory port.
- Adds a memory wait handshake, optional `addi` and `j` support, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath's muxes and write enables.

Parameters:
- ENABLE_ADDI, 1, when 1 decode opcode 001000 (`addi`); when 0 it is illegal.
- ENABLE_JUMP, 1, when 1 decode opcode 000010 (`j`); when 0 it is illegal.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; sampled in DECODE.
- mem_ready  input  1  memory access completes this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- i_or_d  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  writeback source: 1 = MDR, 0 = ALUOut.
- reg_dst  output  1  destination register: 1 = rd, 0 = rt.
- reg_write  output  1  register file write.
- alu_src_a  output  1  0 = PC, 1 = A.
- alu_src_b  output  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  output  2  00 = add, 01 = sub, 10 = funct.
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  sticky trap flag.
- instr_count  output  CNT_W  retired-instruction count.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset is synchronous and active-high on one clock.
- Reset takes priority over everything, including mem_ready, in any state. On reset:
  - state = FETCH (0); instr_count = 0; illegal_op = 0; op_q = 0.
  - Outputs then take FETCH values.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=12.
  - Codes 13–15 are unreachable; if entered, go to TRAP.
- Outputs are decoded from state (plus mem_ready where noted). Any signal not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Register op_q <= opcode.
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 with ENABLE_JUMP -> JUMP
    - 001000 with ENABLE_ADDI -> ADDI_EX
    - anything else -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: op_q=100011 -> MEM_RD, otherwise MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WR:
  - mem_write=1, i_or_d=1.
  - Hold until mem_ready=1, then FETCH.
  - mem_write stays high for every wait cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- TRAP:
  - illegal_op=1; all write and enable outputs are 0.
  - Stay in TRAP until reset.
- Retirement:
  - instr_count increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB.
  - Wraps modulo 2^CNT_W with no saturation.
  - Never counts in TRAP.
- Cycle counts with mem_ready always 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- op_q changes only in DECODE; opcode changes in later states are ignored.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

Test Plan:
- R-type 000000, mem_ready=1:
  - states 0,1,6,7,0.
  - EXEC shows alu_op=10.
  - R_WB shows reg_write=1, reg_dst=1.
  - instr_count goes 0 -> 1.
- lw 100011 with mem_ready low for 2 cycles in MEM_RD:
  - states 0,1,2,3,3,3,4,0.
  - mem_read=1, i_or_d=1 throughout MEM_RD.
  - MEM_WB shows mem_to_reg=1.
  - 7 cycles total.
- FETCH with mem_ready=0 for 3 cycles:
  - ir_write and pc_write stay 0 until mem_ready=1.
  - Both pulse in that single cycle; then DECODE.
- beq 000100, then j 000010:
  - BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01.
  - JUMP shows pc_write=1, pc_source=10.
  - instr_count = 2.
- With ENABLE_JUMP=0, decode 000010:
  - state goes to 12 with illegal_op=1; outputs held 0.
  - opcode changes are ignored.
  - Reset returns to state 0 with illegal_op=0.
- Reset asserted in MEM_WR with mem_ready=1:
  - next state is 0 and instr_count = 0.
  - With CNT_W=4, 16 R-types wrap instr_count to 0.
